// File: rtl/axil_single_master.sv
// axil_single_master
//   Issues exactly one AXI-lite transaction (read or write) per command taken
//   on a valid/ready request port, and hands RDATA/RRESP or BRESP back on a
//   valid/ready response port. Only one transaction is ever in flight, and a
//   new command is refused until the previous response has been delivered.
//
//   Optional build macro: AXIL_SINGLE_MASTER_LOWPOWER_EN
//     defined   : AWADDR/WDATA/WSTRB read as zero while their VALID is low,
//                 ARADDR reads as zero while ARVALID is low, and the response
//                 payload reads as zero while o_rsp_valid is low.
//     undefined : those outputs show the last latched values; only the VALID
//                 signals qualify them.
module axil_single_master #(
   parameter int C_AXI_ADDR_WIDTH = 4
) (
   input  logic                        M_AXI_ACLK,
   input  logic                        M_AXI_ARESETN,
   // command port
   input  logic                        i_cmd_valid,
   output logic                        o_cmd_ready,
   input  logic                        i_cmd_we,
   input  logic [C_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [31:0]                 i_cmd_data,
   input  logic [3:0]                  i_cmd_strb,
   // response port
   output logic                        o_rsp_valid,
   input  logic                        i_rsp_ready,
   output logic                        o_rsp_we,
   output logic [31:0]                 o_rsp_data,
   output logic [1:0]                  o_rsp_resp,
   // AXI-lite write address channel
   output logic                        M_AXI_AWVALID,
   input  logic                        M_AXI_AWREADY,
   output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]                  M_AXI_AWPROT,
   // AXI-lite write data channel
   output logic                        M_AXI_WVALID,
   input  logic                        M_AXI_WREADY,
   output logic [31:0]                 M_AXI_WDATA,
   output logic [3:0]                  M_AXI_WSTRB,
   // AXI-lite write response channel
   input  logic                        M_AXI_BVALID,
   output logic                        M_AXI_BREADY,
   input  logic [1:0]                  M_AXI_BRESP,
   // AXI-lite read address channel
   output logic                        M_AXI_ARVALID,
   input  logic                        M_AXI_ARREADY,
   output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]                  M_AXI_ARPROT,
   // AXI-lite read data channel
   input  logic                        M_AXI_RVALID,
   output logic                        M_AXI_RREADY,
   input  logic [31:0]                 M_AXI_RDATA,
   input  logic [1:0]                  M_AXI_RRESP
);

   localparam int C_AXI_DATA_WIDTH = 32;
   localparam int C_AXI_STRB_WIDTH = C_AXI_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                        state_q;
   logic                          cmd_ready_q;
   logic                          awvalid_q;
   logic                          wvalid_q;
   logic                          bready_q;
   logic                          arvalid_q;
   logic                          rready_q;
   logic                          rsp_valid_q;
   logic                          rsp_we_q;
   logic [C_AXI_DATA_WIDTH-1:0]   rsp_data_q;
   logic [1:0]                    rsp_resp_q;
   logic [C_AXI_ADDR_WIDTH-1:0]   addr_q;
   logic [C_AXI_DATA_WIDTH-1:0]   data_q;
   logic [C_AXI_STRB_WIDTH-1:0]   strb_q;

   // Single FSM: state, every handshake output and the latched command/response.
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         // o_cmd_ready stays low in reset and rises on the first edge after release.
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_resp_q  <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         strb_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments only; where two statements below hit the
         // same register in one edge, the later one in program order wins.
         // Address/data VALIDs drop on their own handshake and never reassert,
         // independent of which state the FSM is in.
         if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
         if (wvalid_q  && M_AXI_WREADY)  wvalid_q  <= 1'b0;
         if (arvalid_q && M_AXI_ARREADY) arvalid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_ready_q && i_cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  addr_q      <= i_cmd_addr;
                  data_q      <= i_cmd_data;
                  strb_q      <= i_cmd_strb;
                  rsp_we_q    <= i_cmd_we;
                  if (i_cmd_we) begin
                     state_q   <= WRITE;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     bready_q  <= 1'b1;
                  end else begin
                     state_q   <= READ;
                     arvalid_q <= 1'b1;
                     rready_q  <= 1'b1;
                  end
               end
            end

            WRITE: begin
               // B may land together with the last AW/W handshake.
               if (bready_q && M_AXI_BVALID) begin
                  bready_q    <= 1'b0;
                  rsp_resp_q  <= M_AXI_BRESP;
                  rsp_data_q  <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end

            READ: begin
               if (rready_q && M_AXI_RVALID) begin
                  rready_q    <= 1'b0;
                  rsp_resp_q  <= M_AXI_RRESP;
                  rsp_data_q  <= M_AXI_RDATA;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end

            RESP: begin
               if (i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_cmd_ready   = cmd_ready_q;
   assign o_rsp_valid   = rsp_valid_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;

`ifdef AXIL_SINGLE_MASTER_LOWPOWER_EN
   // Payloads forced to zero whenever their qualifying VALID is low.
   assign M_AXI_AWADDR = awvalid_q   ? addr_q     : '0;
   assign M_AXI_WDATA  = wvalid_q    ? data_q     : '0;
   assign M_AXI_WSTRB  = wvalid_q    ? strb_q     : '0;
   assign M_AXI_ARADDR = arvalid_q   ? addr_q     : '0;
   assign o_rsp_data   = rsp_valid_q ? rsp_data_q : '0;
   assign o_rsp_resp   = rsp_valid_q ? rsp_resp_q : '0;
   assign o_rsp_we     = rsp_valid_q ? rsp_we_q   : 1'b0;
`else
   // Payloads show the last latched values; VALID alone qualifies them.
   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_WDATA  = data_q;
   assign M_AXI_WSTRB  = strb_q;
   assign M_AXI_ARADDR = addr_q;
   assign o_rsp_data   = rsp_data_q;
   assign o_rsp_resp   = rsp_resp_q;
   assign o_rsp_we     = rsp_we_q;
`endif

endmodule

// File: doc/axil_single_master.md
# axil_single_master

Single-transaction AXI-lite bus master. It takes one command (read or write) from a simple valid/ready request port, performs exactly one AXI-lite transaction on the master channels, and returns the response (RDATA/RRESP or BRESP) on a valid/ready response port. It sits between control logic (sequencers, debug bridges, test harnesses) and an AXI-lite interconnect or slave, including the empty error-returning slave.

## Interface

- C_AXI_ADDR_WIDTH, 4, AXI-lite address width
- C_AXI_DATA_WIDTH, 32 (localparam, fixed), data width; strobe width is C_AXI_DATA_WIDTH/8
- M_AXI_ACLK  in  1  clock; all logic on rising edge
- M_AXI_ARESETN  in  1  reset, asynchronous active-low
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake
- i_cmd_we  in  1  1=write, 0=read
- i_cmd_addr  in  C_AXI_ADDR_WIDTH  byte address
- i_cmd_data / i_cmd_strb  in  32 / 4  write data and strobes (ignored for reads)
- o_rsp_valid / i_rsp_ready  out/in  1  response handshake
- o_rsp_we  out  1  echo of the command's i_cmd_we
- o_rsp_data  out  32  read data (0 for writes)
- o_rsp_resp  out  2  BRESP or RRESP as received
- M_AXI_AWVALID/AWREADY out/in 1; M_AXI_AWADDR out ADDR_WIDTH; M_AXI_AWPROT out 3 (const 3'b000)
- M_AXI_WVALID/WREADY out/in 1; M_AXI_WDATA out 32; M_AXI_WSTRB out 4
- M_AXI_BVALID in 1; M_AXI_BREADY out 1; M_AXI_BRESP in 2
- M_AXI_ARVALID/ARREADY out/in 1; M_AXI_ARADDR out ADDR_WIDTH; M_AXI_ARPROT out 3 (const 3'b000)
- M_AXI_RVALID in 1; M_AXI_RREADY out 1; M_AXI_RDATA in 32; M_AXI_RRESP in 2

## Operation

- States: IDLE, WRITE, READ, RESP. Reset enters IDLE.
- o_cmd_ready = (state==IDLE). Handshake in IDLE: latch addr/data/strb/we; go to WRITE (we=1) or READ (we=0).
- WRITE: AWVALID and WVALID both rise together on entry. Each drops independently on its own handshake (AWVALID&&AWREADY, WVALID&&WREADY); neither reasserts. BREADY=1 throughout WRITE. B handshake latches BRESP into o_rsp_resp, sets o_rsp_data=0, goes to RESP. B arriving in the same cycle as the final AW/W handshake is legal and accepted.
- READ: ARVALID=1 until ARREADY; RREADY=1 throughout READ. R handshake latches RDATA/RRESP, goes to RESP.
- RESP: o_rsp_valid=1, outputs stable until i_rsp_ready; then IDLE.
- A new command is never accepted while a transaction or undelivered response exists: at most one outstanding transaction.
- AXI VALID signals never deassert before their READY; address/data stable while VALID.
- Async reset mid-transaction: all VALIDs and o_rsp_valid drop immediately, state IDLE; no abandoned-transaction tracking (bus is reset together).
- Reset values: o_cmd_ready=0 during reset, 1 in the first cycle after release; o_rsp_valid, AWVALID, WVALID, ARVALID, BREADY, RREADY = 0; o_rsp_resp=0, o_rsp_data=0, o_rsp_we=0; address/data/strb regs = 0.

## Timing

- Command accepted in cycle N -> AWVALID/WVALID (or ARVALID) high in cycle N+1.
- B/R handshake in cycle M -> o_rsp_valid high in cycle M+1.
- Response accepted in cycle K -> o_cmd_ready high in cycle K+1.
- Minimum command-to-command period with zero-wait slave (READY tied high, response one cycle after address): 4 cycles.
- No combinational path from any AXI input to any AXI output or to o_cmd_ready.

## Configuration

- AXIL_SINGLE_MASTER_LOWPOWER_EN defined: AWADDR/WDATA/WSTRB driven to 0 whenever their VALID is low; ARADDR to 0 whenever ARVALID is low; o_rsp_data/o_rsp_resp/o_rsp_we to 0 whenever o_rsp_valid is low.
- Not defined: those registers hold last latched values; only VALID qualifies them.

## Test plan

- Write 0xDEADBEEF, strb 4'hF, addr 0x4 to slave with READY high, BRESP=00 -> AWADDR=0x4, WDATA=0xDEADBEEF on cycle N+1; rsp we=1, resp=00, data=0.
- Read addr 0x8, slave returns RDATA=0x12345678, RRESP=00 -> rsp we=0, data=0x12345678, resp=00.
- Against the empty error slave: one write, then one read -> resp=11 both; read data=0; no hang.
- AWREADY delayed 3 cycles after WREADY -> WVALID drops after its handshake, AWVALID holds 3 cycles, single response delivered.
- Hold i_rsp_ready=0 for 5 cycles -> o_rsp_valid and payload stable, o_cmd_ready=0, no AXI VALID asserted.
- Deassert M_AXI_ARESETN while ARVALID=1 -> ARVALID=0 immediately; after release o_cmd_ready=1, next read completes normally; with LOWPOWER_EN, ARADDR=0 while idle.
